// File: rtl/sand_fb_writer_pkg.sv
// ---------------------------------------------------------------------------
// sand_pkg : shared definitions for the sand-cell frame buffer.
//   - cell_t       : 2-bit cell type stored per grid cell
//   - state_t      : write-port FSM states (CLR exists only with FB_CLEAR_EN)
//   - GRID_W/GRID_H/CELLS_PER_WORD/WORDS_PER_ROW/FB_WORDS : buffer geometry
//   - cell_addr()  : word address of cell (x, y) = y*5 + x/16
// Optional feature macro: FB_CLEAR_EN (adds the CLR state).
// ---------------------------------------------------------------------------
package sand_pkg;

  localparam int GRID_W         = 80;
  localparam int GRID_H         = 120;
  localparam int CELLS_PER_WORD = 16;
  localparam int WORDS_PER_ROW  = GRID_W / CELLS_PER_WORD;
  localparam int FB_WORDS       = GRID_H * WORDS_PER_ROW;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SAND  = 2'd1,
    CELL_FALL  = 2'd2,
    CELL_WALL  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
`ifdef FB_CLEAR_EN
    ,
    ST_CLR  = 2'd3
`endif
  } state_t;

  // y*5 built as shift-and-add so no multiplier is needed.
  function automatic logic [9:0] cell_addr(input logic [6:0] x, input logic [6:0] y);
    logic [9:0] y10;
    y10 = {3'b000, y};
    return (y10 << 2) + y10 + {7'b0000000, x[6:4]};
  endfunction

endpackage

// File: rtl/sand_fb_writer_if.sv
// ---------------------------------------------------------------------------
// sand_fb_writer_if : single-cell write request channel (valid/ready).
//   wr_valid  master->slave  request valid
//   wr_ready  slave->master  request can be accepted this cycle
//   wr_x      master->slave  cell column (7 bits)
//   wr_y      master->slave  cell row (7 bits)
//   wr_t      master->slave  cell type (2 bits)
// master: the simulation engine; slave: sand_fb_writer.
// ---------------------------------------------------------------------------
interface sand_fb_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_x;
  logic [6:0] wr_y;
  logic [1:0] wr_t;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_t, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_t, output wr_ready);
endinterface

// File: rtl/sand_word_merge.sv
// ---------------------------------------------------------------------------
// sand_word_merge : combinational cell insert into a packed 16-cell word.
//   word_i [31:0]  original word
//   idx_i  [3:0]   cell slot inside the word (bits [2*idx+1:2*idx])
//   t_i    [1:0]   new cell type
//   word_o [31:0]  word_i with the selected slot replaced by t_i
// ---------------------------------------------------------------------------
module sand_word_merge
  import sand_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [3:0]  idx_i,
  input  logic [1:0]  t_i,
  output logic [31:0] word_o
);

  logic [4:0] bit_lo;

  assign bit_lo = {idx_i, 1'b0};

  always_comb begin
    word_o             = word_i;
    word_o[bit_lo +: 2] = t_i;
  end

endmodule

// File: rtl/sand_fb_writer.sv
// ---------------------------------------------------------------------------
// sand_fb_writer : write-side port of the sand-cell frame buffer.
// Accepts single-cell writes and performs read-modify-write on the RAM write
// port: IDLE (issue read) -> RD (capture word) -> WR (write merged word).
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   wr                      request channel (sand_fb_writer_if.slave)
//   ram_addr[9:0]           word address
//   ram_re                  read enable, data returns one cycle later
//   ram_rdata[31:0]         read data
//   ram_we, ram_wdata[31:0] write enable / data
//   busy                    FSM not in IDLE
//   err_oob                 one-cycle pulse after an out-of-range request
// Optional feature macro FB_CLEAR_EN adds:
//   clear_req, clear_t[1:0] fill the whole buffer with {16{clear_t}}
//   clear_done              one-cycle pulse after the last fill write
// ---------------------------------------------------------------------------
module sand_fb_writer #(
  parameter int GRID_W        = sand_pkg::GRID_W,
  parameter int GRID_H        = sand_pkg::GRID_H,
  parameter int WORDS_PER_ROW = GRID_W / 16,
  parameter int FB_WORDS      = GRID_H * WORDS_PER_ROW
) (
  input  logic                clock,
  input  logic                reset,
  sand_fb_writer_if.slave     wr,
  output logic [9:0]          ram_addr,
  output logic                ram_re,
  input  logic [31:0]         ram_rdata,
  output logic                ram_we,
  output logic [31:0]         ram_wdata,
  output logic                busy,
  output logic                err_oob
`ifdef FB_CLEAR_EN
  ,
  input  logic                clear_req,
  input  logic [1:0]          clear_t,
  output logic                clear_done
`endif
);

  import sand_pkg::*;

  localparam logic [6:0] GRID_W_C  = 7'(GRID_W);
  localparam logic [6:0] GRID_H_C  = 7'(GRID_H);
  localparam logic [9:0] LAST_ADDR = 10'(FB_WORDS - 1);

  state_t      state_q;
  logic [9:0]  addr_q;
  logic [3:0]  idx_q;      // x[3:0]; addr_q already carries y and x[6:4]
  logic [1:0]  t_q;
  logic [31:0] word_q;
  logic        err_q;

  logic        in_range;
  logic        clr_start;
  logic        accept;
  logic [9:0]  addr_d;
  logic [31:0] merged;

`ifdef FB_CLEAR_EN
  logic [9:0]  clr_cnt_q;
  logic [1:0]  clr_t_q;
  logic        clr_done_q;

  // Clear wins over a simultaneous write; that write stays pending.
  assign clr_start  = (state_q == ST_IDLE) && clear_req;
  assign clear_done = clr_done_q;
`else
  assign clr_start  = 1'b0;
`endif

  assign wr.wr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign err_oob     = err_q;

  assign in_range = (wr.wr_x < GRID_W_C) && (wr.wr_y < GRID_H_C);
  assign accept   = wr.wr_valid && wr.wr_ready && !clr_start;
  assign addr_d   = cell_addr(wr.wr_x, wr.wr_y);

  sand_word_merge u_merge (
    .word_i (word_q),
    .idx_i  (idx_q),
    .t_i    (t_q),
    .word_o (merged)
  );

  // The read is issued in the accept cycle straight from the request so the
  // RAM data is ready at the RD edge. Reset suppresses any RAM strobe.
  assign ram_re = !reset && accept && in_range;

  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = 32'h0000_0000;
    case (state_q)
      ST_IDLE: ram_addr = addr_d;
      ST_WR: begin
        ram_we    = !reset;
        ram_wdata = merged;
      end
`ifdef FB_CLEAR_EN
      ST_CLR: begin
        ram_addr  = clr_cnt_q;
        ram_we    = !reset;
        ram_wdata = {16{clr_t_q}};
      end
`endif
      default: ram_addr = addr_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      t_q        <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt_q  <= '0;
      clr_t_q    <= '0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_done_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
`ifdef FB_CLEAR_EN
            state_q   <= ST_CLR;
            clr_cnt_q <= '0;
            clr_t_q   <= clear_t;
`endif
          end else if (accept) begin
            if (in_range) begin
              addr_q  <= addr_d;
              idx_q   <= wr.wr_x[3:0];
              t_q     <= wr.wr_t;
              state_q <= ST_RD;
            end else begin
              // Dropped request: no RAM traffic, FSM stays in IDLE.
              err_q <= 1'b1;
            end
          end
        end
        ST_RD: begin
          word_q  <= ram_rdata;
          state_q <= ST_WR;
        end
        ST_WR: state_q <= ST_IDLE;
`ifdef FB_CLEAR_EN
        ST_CLR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q    <= ST_IDLE;
            clr_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 10'd1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sand_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_sand_fb_writer : self-checking bench for sand_fb_writer.
// Hosts a 600-word RAM, keeps a grid-of-cells reference model and checks
// per-cycle RAM traffic, handshake timing and final RAM contents.
// Build with FB_CLEAR_EN defined to exercise the clear feature.
// ---------------------------------------------------------------------------
module tb_sand_fb_writer;
  import sand_pkg::*;

  localparam int H = 4096;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sand_fb_writer_if wr ();

  logic [9:0]  ram_addr;
  logic        ram_re, ram_we, busy, err_oob;
  logic [31:0] ram_rdata, ram_wdata;
`ifdef FB_CLEAR_EN
  logic        clear_req, clear_done;
  logic [1:0]  clear_t;
`endif

  sand_fb_writer dut (
    .clock     (clock),
    .reset     (reset),
    .wr        (wr.slave),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .err_oob   (err_oob)
`ifdef FB_CLEAR_EN
    ,
    .clear_req (clear_req),
    .clear_t   (clear_t),
    .clear_done(clear_done)
`endif
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:599];
  logic        init_mem, pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clock) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (init_mem) begin
      for (int i = 0; i < 600; i++) mem[i] <= seed(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
  end

  // ---------------- per-cycle history ----------------
  int          cyc = 0;
  logic        re_h [H], we_h [H], rdy_h [H], err_h [H], busy_h [H], done_h [H];
  logic [9:0]  addr_h [H];
  logic [31:0] wd_h [H];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cyc < H) begin
      re_h[cyc]   = ram_re;
      we_h[cyc]   = ram_we;
      rdy_h[cyc]  = wr.wr_ready;
      err_h[cyc]  = err_oob;
      busy_h[cyc] = busy;
      addr_h[cyc] = ram_addr;
      wd_h[cyc]   = ram_wdata;
`ifdef FB_CLEAR_EN
      done_h[cyc] = clear_done;
`else
      done_h[cyc] = 1'b0;
`endif
    end
  end

  // ---------------- reference model: grid of cells ----------------
  logic [1:0] cells [0:119][0:79];

  function automatic logic [31:0] pack(input int a);
    logic [31:0] w;
    int r, c;
    r = a / 5;
    c = (a % 5) * 16;
    w = '0;
    for (int i = 0; i < 16; i++) w[2*i +: 2] = cells[r][c+i];
    return w;
  endfunction

  task automatic set_word(input int a, input logic [31:0] w);
    int r, c;
    r = a / 5;
    c = (a % 5) * 16;
    for (int i = 0; i < 16; i++) cells[r][c+i] = w[2*i +: 2];
  endtask

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic preload(input int a, input logic [31:0] w);
    pl_addr = 10'(a);
    pl_data = w;
    pl_we   = 1'b1;
    @(posedge clock); #1;
    pl_we   = 1'b0;
    set_word(a, w);
  endtask

  task automatic issue(input logic [6:0] x, input logic [6:0] y, input logic [1:0] t,
                       output int acc);
    logic ok;
    wr.wr_x = x;
    wr.wr_y = y;
    wr.wr_t = t;
    wr.wr_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      ok = wr.wr_ready;
`ifdef FB_CLEAR_EN
      ok = ok && !clear_req;
`endif
      if (ok) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 1000 cycles");
    end
    @(posedge clock); #1;
    wr.wr_valid = 1'b0;
  endtask

  task automatic check_txn(input int acc, input logic [6:0] x, input logic [6:0] y,
                           input logic [1:0] t);
    int ea;
    logic [31:0] ew;
    if (acc < 0) return;
    while (cyc < acc + 3) @(posedge clock);
    #1;
    if (x < 7'd80 && y < 7'd120) begin
      ea = int'(y) * 5 + int'(x) / 16;
      cells[y][x] = t;
      ew = pack(ea);
      chk("re_at_accept", 32'(re_h[acc]), 32'd1);
      chk("re_addr", 32'(addr_h[acc]), 32'(ea));
      chk("ready_low_c1", 32'(rdy_h[acc+1]), 32'd0);
      chk("ready_low_c2", 32'(rdy_h[acc+2]), 32'd0);
      chk("busy_c1", 32'(busy_h[acc+1]), 32'd1);
      chk("no_we_c1", 32'(we_h[acc+1]), 32'd0);
      chk("we_c2", 32'(we_h[acc+2]), 32'd1);
      chk("we_addr", 32'(addr_h[acc+2]), 32'(ea));
      chk("we_data", wd_h[acc+2], ew);
    end else begin
      chk("oob_no_re", 32'(re_h[acc]), 32'd0);
      chk("oob_no_we_c1", 32'(we_h[acc+1]), 32'd0);
      chk("oob_no_we_c2", 32'(we_h[acc+2]), 32'd0);
      chk("oob_err_pulse", 32'(err_h[acc+1]), 32'd1);
      chk("oob_ready_c1", 32'(rdy_h[acc+1]), 32'd1);
      chk("oob_idle_c1", 32'(busy_h[acc+1]), 32'd0);
    end
  endtask

  typedef struct {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [1:0]  t;
    int          pre_addr;
    logic [31:0] pre_word;
    bit          oob;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int a, a1, a2, a3, bad;
    logic [6:0] rx, ry;
    logic [1:0] rt;

    vecs[0] = '{7'd0,  7'd0,   2'd3, 0,   32'h0000_0000, 1'b0, 10'd0,   32'h0000_0003};
    vecs[1] = '{7'd79, 7'd119, 2'd1, 599, 32'hFFFF_FFFF, 1'b0, 10'd599, 32'h7FFF_FFFF};
    vecs[2] = '{7'd40, 7'd60,  2'd2, 302, 32'h1234_5678, 1'b0, 10'd302, 32'h1236_5678};
    vecs[3] = '{7'd80, 7'd0,   2'd2, 0,   32'h0000_0000, 1'b1, 10'd0,   32'h0};
    vecs[4] = '{7'd5,  7'd120, 2'd1, 0,   32'h0000_0000, 1'b1, 10'd0,   32'h0};

    reset = 1'b1;
    init_mem = 1'b1;
    pl_we = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    wr.wr_valid = 1'b0;
    wr.wr_x = '0;
    wr.wr_y = '0;
    wr.wr_t = '0;
`ifdef FB_CLEAR_EN
    clear_req = 1'b0;
    clear_t = 2'd0;
`endif
    repeat (3) @(posedge clock);
    #1;
    init_mem = 1'b0;
    for (int i = 0; i < 600; i++) set_word(i, seed(i));

    // Reset state
    @(negedge clock);
    chk("rst_ready", 32'(wr.wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_re", 32'(ram_re), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_err", 32'(err_oob), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      preload(vecs[i].pre_addr, vecs[i].pre_word);
      issue(vecs[i].x, vecs[i].y, vecs[i].t, a);
      check_txn(a, vecs[i].x, vecs[i].y, vecs[i].t);
      if (!vecs[i].oob && a >= 0) begin
        chk("tbl_addr", 32'(addr_h[a+2]), 32'(vecs[i].exp_addr));
        chk("tbl_wdata", wd_h[a+2], vecs[i].exp_wdata);
      end
    end

    // Back-to-back writes to the same word, second request held on valid
    preload(11, 32'h0);
    issue(7'd17, 7'd2, 2'd1, a1);
    issue(7'd18, 7'd2, 2'd3, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'd3);
    check_txn(a1, 7'd17, 7'd2, 2'd1);
    check_txn(a2, 7'd18, 7'd2, 2'd3);
    chk("b2b_word11", mem[11], 32'h0000_0034);

    // Out-of-range pair, each followed by an immediate accept
    issue(7'd80, 7'd0, 2'd1, a1);
    issue(7'd5, 7'd120, 2'd2, a2);
    issue(7'd1, 7'd1, 2'd1, a3);
    chk("oob_next_accept1", 32'(a2 - a1), 32'd1);
    chk("oob_next_accept2", 32'(a3 - a2), 32'd1);
    check_txn(a1, 7'd80, 7'd0, 2'd1);
    check_txn(a2, 7'd5, 7'd120, 2'd2);
    check_txn(a3, 7'd1, 7'd1, 2'd1);

    // Reset while in RD: no write, back in IDLE
    preload(20, 32'hDEAD_BEEF);
    issue(7'd3, 7'd4, 2'd1, a);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    while (cyc < a + 4) @(posedge clock);
    #1;
    chk("rstrd_no_we1", 32'(we_h[a+1]), 32'd0);
    chk("rstrd_no_we2", 32'(we_h[a+2]), 32'd0);
    chk("rstrd_ready", 32'(rdy_h[a+2]), 32'd1);
    chk("rstrd_idle", 32'(busy_h[a+2]), 32'd0);
    chk("rstrd_mem", mem[20], 32'hDEAD_BEEF);

    // Reset while in WR: the write strobe is suppressed
    issue(7'd3, 7'd4, 2'd2, a);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    while (cyc < a + 4) @(posedge clock);
    #1;
    chk("rstwr_no_we", 32'(we_h[a+2]), 32'd0);
    chk("rstwr_ready", 32'(rdy_h[a+3]), 32'd1);
    chk("rstwr_mem", mem[20], 32'hDEAD_BEEF);

    // Random writes against the cell-grid model
    for (int n = 0; n < 40; n++) begin
      rx = 7'($urandom_range(0, 84));
      ry = 7'($urandom_range(0, 124));
      rt = 2'($urandom_range(0, 3));
      issue(rx, ry, rt, a);
      check_txn(a, rx, ry, rt);
    end

`ifdef FB_CLEAR_EN
    // Clear with a simultaneous write request
    clear_t = 2'd2;
    clear_req = 1'b1;
    wr.wr_x = 7'd33;
    wr.wr_y = 7'd7;
    wr.wr_t = 2'd1;
    wr.wr_valid = 1'b1;
    @(negedge clock);
    a1 = cyc;
    @(posedge clock); #1;
    clear_req = 1'b0;
    issue(7'd33, 7'd7, 2'd1, a);
    chk("clr_pending_accept", 32'(a), 32'(a1 + 601));
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      if (!(we_h[a1+1+k] === 1'b1 && addr_h[a1+1+k] === 10'(k) &&
            wd_h[a1+1+k] === 32'hAAAA_AAAA && re_h[a1+1+k] === 1'b0 &&
            rdy_h[a1+1+k] === 1'b0 && busy_h[a1+1+k] === 1'b1))
        bad++;
    end
    chk("clr_writes_bad", 32'(bad), 32'd0);
    chk("clr_write_skipped_c0", 32'(re_h[a1]), 32'd0);
    bad = 0;
    for (int k = a1; k < a1 + 601; k++) if (done_h[k] === 1'b1) bad++;
    chk("clr_done_early", 32'(bad), 32'd0);
    chk("clr_done_pulse", 32'(done_h[a1+601]), 32'd1);
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 80; c++) cells[r][c] = 2'd2;
    check_txn(a, 7'd33, 7'd7, 2'd1);
    chk("clr_done_once", 32'(done_h[a+1]), 32'd0);
    chk("clr_word37", mem[37], 32'hAAAA_AAA6);
`endif

    // Whole buffer against model
    repeat (2) @(posedge clock);
    #1;
    bad = 0;
    for (int i = 0; i < 600; i++) if (mem[i] !== pack(i)) bad++;
    chk("final_mem_bad_words", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sand_fb_writer.md
Name: sand_fb_writer

Overview:
- Write-side port of the sand-cell frame buffer. Consumers of the buffer read packed 32-bit words; this block is the producer that fills them.
- Accepts single-cell writes (x, y, 2-bit cell type) from the simulation engine over a valid/ready handshake.
- Performs read-modify-write on the write port of the dual-port frame-buffer RAM. The scan-out side owns the other RAM port.
- Grid is 80x120 cells (8x4 screen pixels per cell). Words hold 16 cells each, giving 600 words.

Parameters:
- GRID_W, 80, cells per row; must be a multiple of 16.
- GRID_H, 120, number of rows.
- WORDS_PER_ROW, 5, equal to GRID_W/16.
- FB_WORDS, 600, equal to GRID_H*WORDS_PER_ROW.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  block can accept a request this cycle.
- wr_x  in  7  cell column.
- wr_y  in  7  cell row.
- wr_t  in  2  cell type: 0 empty, 1/2 sand, 3 wall.
- ram_addr  out  10  word address.
- ram_re  out  1  read enable; data returns 1 cycle later.
- ram_rdata  in  32  read data.
- ram_we  out  1  write enable.
- ram_wdata  out  32  write data.
- busy  out  1  FSM not in IDLE.
- err_oob  out  1  one-cycle pulse when a request is dropped as out of range.

Behaviour:
- Reset: all outputs 0 except wr_ready, which is 1 (FSM in IDLE). Latched request registers are cleared.
- A reset asserted in any state returns to IDLE on the next edge. Any in-flight RMW is abandoned with no ram_we that cycle.
- Handshake: a request is accepted on a cycle where wr_valid && wr_ready. wr_ready = (state == IDLE).
- FSM states: IDLE -> RD -> WR -> IDLE.
  - IDLE: on accept, latch x/y/t and compute addr = y*5 + x[6:4] (10-bit, as (y<<2)+y+x[6:4]). Drive ram_addr and ram_re=1 in the same cycle, combinationally from the request. Go to RD.
  - RD: ram_re=0, ram_addr held. Capture ram_rdata into the word register. Go to WR.
  - WR: ram_we=1, ram_addr held. ram_wdata = captured word with bits [2i+1:2i] replaced by t, where i = x[3:0]; all other bits unchanged. Go to IDLE.
- Throughput: one write per 3 cycles.
  - The RAM word is updated at the WR edge, 2 cycles after accept.
  - Back-to-back writes to the same word are coherent because the next read issues after the previous write edge. The RAM must return written data on a following-cycle read (no read-during-write hazard on this port).
- Out of range (x >= GRID_W or y >= GRID_H): the request is accepted and dropped. No ram_re/ram_we is issued. err_oob pulses on the cycle after accept. The FSM stays in IDLE.
- Cell type 2 (falling sand) is stored as-is; no remapping.

Optional Feature:
- Macro: FB_CLEAR_EN.
- When defined, three ports are added:
  - clear_req in 1.
  - clear_t in 2.
  - clear_done out 1 (one-cycle pulse).
- clear_req sampled high in IDLE takes priority over wr_valid on the same cycle; that write is not accepted.
- The FSM enters CLR and writes the word {16{clear_t}} to addresses 0..599, one per cycle with ram_we=1 and no read.
  - A 10-bit counter is used; it stops at FB_WORDS-1.
  - clear_done pulses on the cycle after the final write. The FSM then returns to IDLE.
- wr_ready=0 and busy=1 throughout the clear. Reset aborts the clear.
- When undefined: no extra ports, no CLR state. Behaviour is identical to the above minus the clear.

Decomposition:
- Package sand_pkg holds:
  - typedef cell_t (logic [1:0]) with enum values CELL_EMPTY, CELL_SAND, CELL_FALL, CELL_WALL.
  - Constants GRID_W, GRID_H, CELLS_PER_WORD=16, FB_WORDS.
  - Function cell_addr(x, y).
- One sub-module: sand_word_merge, combinational. Inputs are word, idx[3:0] and t; output is the merged word. It is reused by any future RMW client.

Test Plan:
- Reset, then write (x=0, y=0, t=3) with RAM word 0 = 0x00000000:
  - ram_re at cycle 0.
  - ram_we at cycle 2 with addr 0, wdata 0x00000003.
  - wr_ready low for cycles 1-2.
- Write (x=79, y=119, t=1) with RAM word 599 = 0xFFFFFFFF -> addr 599, wdata 0x7FFFFFFF.
- Two back-to-back writes to the same word:
  - First write (x=17, y=2, t=1); second write (x=18, y=2, t=3).
  - Initial word 11 = 0 -> final word 11 = 0x0000003 4 with no gaps, i.e. 0x00000034.
  - The second request is held on wr_valid until wr_ready returns.
- Write (x=80, y=0) and write (x=5, y=120) -> err_oob pulse for each; no ram_re/ram_we; next request accepted on the following cycle.
- Assert reset in the RD state -> no ram_we. IDLE and wr_ready=1 after the edge; RAM contents unchanged.
- FB_CLEAR_EN build: clear_req with clear_t=2, together with a simultaneous wr_valid:
  - 600 consecutive writes of 0xAAAAAAAA to addresses 0..599.
  - clear_done pulses once.
  - The pending write is accepted afterward and lands on the cleared word.
